// File: rtl/aes_issue_sched.sv
// rtl/aes_issue_sched.sv - two-requester issue scheduler for a fixed-latency AES-128 core
// Credit admission bounds in-flight plus buffered blocks so the output FIFO never overflows.
module aes_issue_sched #(
  parameter int LAT   = 21,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_state,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_state,
  input  logic [127:0] req1_key,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_id,
  output logic         busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [LAT-1:0] dl_vld_q, dl_vld_d;
  logic [LAT-1:0] dl_id_q, dl_id_d;

  logic [127:0]   fifo_data_q [DEPTH];
  logic [DEPTH-1:0] fifo_id_q;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic           pref_q, pref_d;

  logic [CW-1:0]  used;
  logic           credit_ok;
  logic           grant;
  logic           grant_id;
  logic           push;
  logic           pop;

  // Grant is held low during reset so no requester sees ready while state is being cleared.
  always_comb begin
    used      = inflight_q + count_q;
    credit_ok = !rst && (used < DEPTH_C);
    grant     = 1'b0;
    grant_id  = 1'b0;
    if (credit_ok) begin
      if (req0_valid && req1_valid) begin
        grant    = 1'b1;
        grant_id = pref_q;
      end else if (req0_valid) begin
        grant    = 1'b1;
        grant_id = 1'b0;
      end else if (req1_valid) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  assign req0_ready = grant && !grant_id;
  assign req1_ready = grant && grant_id;

  always_comb begin
    core_state = '0;
    core_key   = '0;
    if (grant) begin
      core_state = grant_id ? req1_state : req0_state;
      core_key   = grant_id ? req1_key   : req0_key;
    end
  end

  assign push      = dl_vld_q[LAT-1];
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    dl_vld_d   = {dl_vld_q[LAT-2:0], grant};
    dl_id_d    = {dl_id_q[LAT-2:0], grant_id};
    pref_d     = grant ? ~grant_id : pref_q;
    head_d     = pop  ? head_q + PW'(1) : head_q;
    tail_d     = push ? tail_q + PW'(1) : tail_q;

    inflight_d = inflight_q;
    case ({grant, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_vld_q   <= '0;
      dl_id_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      pref_q     <= 1'b0;
    end else begin
      dl_vld_q   <= dl_vld_d;
      dl_id_q    <= dl_id_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      pref_q     <= pref_d;
    end
  end

  // Storage needs no reset: entries are only visible through out_valid-gated outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[tail_q] <= core_out;
      fifo_id_q[tail_q]   <= dl_id_q[LAT-1];
    end
  end

  assign out_data = out_valid ? fifo_data_q[head_q] : '0;
  assign out_id   = out_valid ? fifo_id_q[head_q]   : 1'b0;
  assign busy     = (inflight_q != '0) || (count_q != '0);

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(push && (count_q == DEPTH_C))
  );

  a_credit_bound: assert property (
    @(posedge clk) disable iff (rst) (used <= DEPTH_C)
  );

endmodule

// File: tb/tb_aes_issue_sched.sv
// tb/tb_aes_issue_sched.sv - directed bench for aes_issue_sched with a behavioural core stand-in
// The stand-in core returns the FIPS-197 ciphertext for the reference vector and a keyed mix otherwise.
module tb_aes_issue_sched;

  localparam int LAT   = 21;
  localparam int DEPTH = 4;
  localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [127:0] req0_state, req0_key;
  logic         req1_valid, req1_ready;
  logic [127:0] req1_state, req1_key;
  logic [127:0] core_state, core_key, core_out;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         out_id;
  logic         busy;

  logic [127:0] core_pipe [LAT];
  logic [128:0] sb_q [$];
  int errors = 0;
  int checks = 0;

  aes_issue_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_state(req0_state), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_state(req1_state), .req1_key(req1_key),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
    if (s == AES_PT && k == AES_KEY) return AES_CT;
    return s ^ {k[63:0], k[127:64]} ^ 128'hc3c3_5a5a_0f0f_9696_c3c3_5a5a_0f0f_9696;
  endfunction

  always @(posedge clk) begin
    core_pipe[0] <= core_f(core_state, core_key);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LAT-1];

  // Scoreboard: expected results queued in grant order, compared at each pop.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      check("one_ready", 128'(req0_ready & req1_ready), 128'd0);
      if (out_valid && out_ready) begin
        check("sb_underflow", 128'(sb_q.size() == 0), 128'd0);
        if (sb_q.size() != 0) begin
          check("out_id", 128'(out_id), 128'(sb_q[0][128]));
          check("out_data", out_data, sb_q[0][127:0]);
          void'(sb_q.pop_front());
        end
      end
      if (req0_valid && req0_ready) sb_q.push_back({1'b0, core_f(req0_state, req0_key)});
      if (req1_valid && req1_ready) sb_q.push_back({1'b1, core_f(req1_state, req1_key)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int grants;
    int gids[$];
    int first_after;
    int first_after_id;
    int stale;
    logic g0, g1;

    rst = 1'b1;
    req0_valid = 1'b1; req0_state = '0; req0_key = '0;
    req1_valid = 1'b0; req1_state = '0; req1_key = '0;
    out_ready  = 1'b0;

    // Reset state, with a requester already asserting valid.
    tick(); tick(); smp();
    check("rst_req0_ready", 128'(req0_ready), 128'd0);
    check("rst_req1_ready", 128'(req1_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_id", 128'(out_id), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    tick();
    req0_valid = 1'b0;
    rst = 1'b0;

    // Single reference block, latency LAT+1.
    tick();
    req0_valid = 1'b1; req0_key = AES_KEY; req0_state = AES_PT; out_ready = 1'b1;
    smp();
    check("t1_grant", 128'(req0_ready), 128'd1);
    check("t1_core_key", core_key, AES_KEY);
    tick();
    req0_valid = 1'b0;
    smp();
    check("t1_ready_one_cycle", 128'(req0_ready), 128'd0);
    check("t1_core_idle", core_state, 128'd0);
    for (int k = 2; k <= 22; k++) begin
      tick();
      smp();
      if (k == 5)  check("t1_busy", 128'(busy), 128'd1);
      if (k == 21) check("t1_not_early", 128'(out_valid), 128'd0);
      if (k == 22) begin
        check("t1_out_valid", 128'(out_valid), 128'd1);
        check("t1_out_data", out_data, AES_CT);
        check("t1_out_id", 128'(out_id), 128'd0);
      end
    end
    tick(); smp();
    check("t1_busy_clear", 128'(busy), 128'd0);
    check("t1_out_valid_clear", 128'(out_valid), 128'd0);

    // Both requesters streaming: alternation and credit stall.
    tick();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_state = 128'h100; req1_state = 128'h200;
    req0_key = 128'h0f0e0d0c0b0a09080706050403020100; req1_key = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    first_after = -1; first_after_id = -1;
    for (int t = 0; t < 30; t++) begin
      smp();
      g0 = req0_ready; g1 = req1_ready;
      if (g0 || g1) begin
        if (t <= 22) gids.push_back(g1 ? 1 : 0);
        else if (first_after < 0) begin
          first_after = t;
          first_after_id = g1 ? 1 : 0;
        end
      end
      tick();
      if (g0) req0_state = req0_state + 128'd1;
      if (g1) req1_state = req1_state + 128'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t2_grant_count", 128'(gids.size()), 128'd4);
    for (int i = 0; i < gids.size() && i < 4; i++) check("t2_grant_order", 128'(gids[i]), 128'(i % 2));
    check("t2_resume_cycle", 128'(first_after), 128'd23);
    check("t2_resume_id", 128'(first_after_id), 128'd0);
    repeat (60) tick();
    smp();
    check("t2_drained", 128'(busy), 128'd0);

    // Consumer stalled: fill to DEPTH, then drain and resume.
    tick();
    out_ready = 1'b0; req0_valid = 1'b1; req0_state = 128'h300;
    grants = 0;
    for (int t = 0; t < 40; t++) begin
      smp();
      g0 = req0_ready;
      if (g0) grants++;
      tick();
      if (g0) req0_state = req0_state + 128'd1;
    end
    check("t3_grants", 128'(grants), 128'(DEPTH));
    smp();
    check("t3_full_valid", 128'(out_valid), 128'd1);
    check("t3_full_noready", 128'(req0_ready), 128'd0);
    check("t3_full_busy", 128'(busy), 128'd1);
    tick();
    out_ready = 1'b1;
    smp();
    check("t3_pop_cycle_noready", 128'(req0_ready), 128'd0);
    tick(); smp();
    check("t3_resume", 128'(req0_ready), 128'd1);
    tick();
    req0_valid = 1'b0; req0_state = req0_state + 128'd1;
    smp(); check("t3_drain3", 128'(out_valid), 128'd1);
    tick(); smp(); check("t3_drain4", 128'(out_valid), 128'd1);
    tick(); smp(); check("t3_drained", 128'(out_valid), 128'd0);
    repeat (30) tick();

    // Push and pop together at count 2.
    out_ready = 1'b0; req0_valid = 1'b1; req0_state = 128'h400;
    smp(); check("t4_a", 128'(req0_ready), 128'd1);
    tick(); req0_state = req0_state + 128'd1;
    smp(); check("t4_b", 128'(req0_ready), 128'd1);
    tick(); req0_valid = 1'b0; req0_state = req0_state + 128'd1;
    repeat (28) tick();
    req0_valid = 1'b1;
    smp(); check("t4_c", 128'(req0_ready), 128'd1);
    tick(); req0_state = req0_state + 128'd1;
    smp(); check("t4_d", 128'(req0_ready), 128'd1);
    tick(); req0_valid = 1'b0; req0_state = req0_state + 128'd1;
    repeat (19) tick();
    out_ready = 1'b1;
    smp(); check("t4_head_valid", 128'(out_valid), 128'd1);
    tick();
    tick();
    out_ready = 1'b0; req0_valid = 1'b1;
    grants = 0;
    for (int t = 0; t < 10; t++) begin
      smp();
      g0 = req0_ready;
      if (g0) grants++;
      tick();
      if (g0) req0_state = req0_state + 128'd1;
    end
    req0_valid = 1'b0;
    check("t4_count_two", 128'(grants), 128'(DEPTH - 2));
    out_ready = 1'b1;
    repeat (40) tick();
    smp(); check("t4_drained", 128'(busy), 128'd0);

    // Reset with 3 in flight and 1 buffered.
    tick();
    out_ready = 1'b0; req0_valid = 1'b1; req0_state = 128'h500;
    smp(); check("t5_first", 128'(req0_ready), 128'd1);
    tick(); req0_valid = 1'b0; req0_state = req0_state + 128'd1;
    repeat (4) tick();
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(); check("t5_inflight_grant", 128'(req0_ready), 128'd1);
      tick(); req0_state = req0_state + 128'd1;
    end
    req0_valid = 1'b0;
    repeat (15) tick();
    smp();
    check("t5_buffered", 128'(out_valid), 128'd1);
    check("t5_busy_pre", 128'(busy), 128'd1);
    tick();
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", 128'(out_valid), 128'd0);
    check("t5_rst_busy", 128'(busy), 128'd0);
    tick(); tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    req1_valid = 1'b1; req1_state = AES_PT; req1_key = AES_KEY;
    smp(); check("t5_fresh_grant", 128'(req1_ready), 128'd1);
    tick(); req1_valid = 1'b0;
    stale = 0;
    for (int k = 1; k <= 22; k++) begin
      smp();
      if (k < 22) begin
        if (out_valid) stale++;
        tick();
      end else begin
        check("t5_out_valid", 128'(out_valid), 128'd1);
        check("t5_out_data", out_data, AES_CT);
        check("t5_out_id", 128'(out_id), 128'd1);
      end
    end
    check("t5_no_stale", 128'(stale), 128'd0);
    repeat (5) tick();
    smp(); check("t5_drained", 128'(busy), 128'd0);

    // Pointer prefers req1; req0 idle; alternating valid pattern.
    tick();
    req0_valid = 1'b1;
    smp(); check("t6_req0", 128'(req0_ready), 128'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_state = 128'h600;
    smp();
    check("t6_req1_only", 128'(req1_ready), 128'd1);
    check("t6_req0_idle", 128'(req0_ready), 128'd0);
    tick();
    req1_valid = 1'b0;
    repeat (30) tick();
    for (int t = 0; t < 4; t++) begin
      req1_valid = 1'b1;
      req0_valid = (t % 2 == 0);
      req1_state = 128'h700 + 128'(t);
      smp();
      check("t6_alt_req0", 128'(req0_ready), 128'(t % 2 == 0));
      check("t6_alt_req1", 128'(req1_ready), 128'(t % 2 == 1));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (40) tick();
    smp();
    check("end_busy", 128'(busy), 128'd0);
    check("end_out_valid", 128'(out_valid), 128'd0);
    check("end_sb_empty", 128'(sb_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_issue_sched.md
Name: aes_issue_sched

Overview:
- Issue scheduler wrapped around the fully pipelined AES-128 encryption core.
- Arbitrates two requesters onto the core's single plaintext/key input, one block per cycle.
- Tracks in-flight blocks through a valid/ID delay line matched to core latency, then captures results into an output FIFO.
- Credit-based admission means the FIFO can never overflow, because the core pipeline cannot be stalled.

Parameters:
- LAT, 21, clock edges from core input sample to matching valid result on core_out.
- DEPTH, 4, output FIFO entries; also the total in-flight + buffered credit limit (power of 2, ≥2).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a block
- req0_ready  out  1  requester 0 block accepted this cycle when valid&ready
- req0_state  in  128  requester 0 plaintext
- req0_key  in  128  requester 0 key
- req1_valid / req1_ready / req1_state / req1_key: same as requester 0, for requester 1
- core_state  out  128  plaintext to core
- core_key  out  128  key to core
- core_out  in  128  ciphertext from core
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  128  ciphertext at FIFO head
- out_id  out  1  requester index of head
- busy  out  1  any block in flight or buffered

Behaviour:
- Reset (async assert, sync release):
  - delay line valids = 0; FIFO empty; credit count = 0; RR pointer = requester 0 preferred.
  - Outputs out_valid=0, req0_ready=0, req1_ready=0, busy=0, out_id=0, out_data=0.
- Credits:
  - used = inflight + fifo_count, width clog2(DEPTH)+1.
  - Issue permitted only when used < DEPTH.
  - A credit freed by a pop becomes usable the following cycle, not the same cycle.
- Arbitration (combinational in issue cycle):
  - If credit is available and exactly one reqN_valid is high, grant that requester.
  - If both are valid, grant the one not granted last; update the pointer only on a grant.
  - reqN_ready = grant to N. At most one ready is high per cycle.
  - Ready never depends on the other requester's ready.
- Core drive:
  - core_state/core_key = the granted requester's state/key.
  - With no grant, both are 0.
  - The core samples them on the grant edge.
- Delay line:
  - LAT-stage shift register of {valid, id}; stage 0 loads {grant, granted_id} each edge.
  - When the last stage is valid, core_out is written to the FIFO tail with that id on the next edge.
  - Accept-to-out_valid latency is exactly LAT+1 cycles when the FIFO is empty.
- FIFO:
  - Circular buffer, pointer wrap at DEPTH.
  - Pop on out_valid & out_ready. Push and pop may occur in the same cycle; count is unchanged.
  - Credits guarantee no push when full; a push when full is a design error and must be flagged by an assertion.
- inflight:
  - +1 on grant, −1 when a block leaves the delay line into the FIFO; both in one cycle leave it unchanged.
  - fifo_count: +1 push, −1 pop.
- Ordering: results emerge in grant order regardless of requester.
- busy = (inflight != 0) | (fifo_count != 0).
- Reset mid-operation: all in-flight and buffered blocks are discarded. Core data is ignored until new grants propagate, since the core itself has no reset.
- Continuous streaming:
  - With out_ready held high, throughput is min(DEPTH/(LAT+2), 1) blocks per cycle.
  - With the default DEPTH=4, issue stalls after 4 grants until the first pop.

Test Plan:
- Reset, then req0 with key 000102030405060708090a0b0c0d0e0f, state 00112233445566778899aabbccddeeff, out_ready=1:
  - req0_ready high for 1 cycle.
  - out_valid rises exactly 22 cycles later with out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_id=0.
  - busy then clears.
- Both requesters valid continuously, out_ready=1:
  - Grants alternate 0,1,0,1.
  - After 4 grants, no ready until the first pop frees credit.
  - out_id sequence 0,1,0,1 with matching ciphertexts.
- out_ready=0, req0 streaming:
  - Exactly DEPTH=4 grants, then ready stays 0.
  - The FIFO fills to 4 with no overflow assertion.
  - Raising out_ready drains 4 results in order, and issue resumes 1 cycle after the first pop.
- Simultaneous push and pop with FIFO at count 2: count stays 2 and head/tail pointers wrap correctly across index DEPTH−1→0.
- Assert rst mid-stream with 3 blocks in flight and 1 buffered:
  - out_valid and busy drop immediately.
  - No stale result is ever emitted.
  - A fresh request after release returns the correct ciphertext at LAT+1.
- Only req1 valid while pointer prefers req1: req1 is granted. Grant with req0 idle never starves req1 under alternating valid patterns.
